// File: rtl/mig_ui_adapter.sv
// mig_ui_adapter: maps single-word bridge requests onto one-beat MIG 7-series UI write/read transactions.
module mig_ui_adapter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 27,
    parameter int APP_DATA_W = 128,
    parameter int ADDR_SHIFT = 1
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_reset_i,
    input  logic                    init_calib_complete_i,
    input  logic                    en_i,
    input  logic                    w_en_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic [DATA_W/8-1:0]     strb_i,
    output logic                    ready_o,
    output logic                    w_ready_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    valid_o,
    output logic [ADDR_W-1:0]       app_addr_o,
    output logic [2:0]              app_cmd_o,
    output logic                    app_en_o,
    input  logic                    app_rdy_i,
    output logic [APP_DATA_W-1:0]   app_wdf_data_o,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask_o,
    output logic                    app_wdf_wren_o,
    output logic                    app_wdf_end_o,
    input  logic                    app_wdf_rdy_i,
    input  logic [APP_DATA_W-1:0]   app_rd_data_i,
    input  logic                    app_rd_data_valid_i,
    input  logic                    app_rd_data_end_i
);
    localparam int LANES  = APP_DATA_W / DATA_W;
    localparam int SB     = DATA_W / 8;
    localparam int OFF_LO = $clog2(SB);
    localparam int LANE_W = LANES > 1 ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d, valid_q, valid_d;
    logic                    en_q, en_d, wren_q, wren_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [ADDR_W-1:0]       addr_q, addr_d, aligned;
    logic [2:0]              cmd_q, cmd_d;
    logic [APP_DATA_W-1:0]   wdata_q, wdata_d;
    logic [APP_DATA_W/8-1:0] mask_q, mask_d, mask_new;
    logic [LANE_W-1:0]       lane_q, lane_d, lane_in;

    assign lane_in = LANES > 1 ? addr_i[OFF_LO +: LANE_W] : '0;
    assign aligned = addr_i & ~ADDR_W'(APP_DATA_W / 8 - 1);

    // Only the selected lane may write; every other byte of the beat is masked.
    always_comb begin
        mask_new = '1;
        for (int k = 0; k < LANES; k++)
            for (int b = 0; b < SB; b++)
                mask_new[k*SB+b] = !(lane_in == LANE_W'(k) && strb_i[b]);
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        en_d    = en_q;
        wren_d  = wren_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: if (en_i && ready_q) begin
                state_d = w_en_i ? WR : RD_CMD;
                addr_d  = aligned >> ADDR_SHIFT;
                cmd_d   = w_en_i ? 3'b000 : 3'b001;
                en_d    = 1'b1;
                wren_d  = w_en_i;
                wdata_d = {LANES{data_i}};
                mask_d  = mask_new;
                lane_d  = lane_in;
            end
            // Command and write-data halves retire independently.
            WR: begin
                en_d    = en_q && !app_rdy_i;
                wren_d  = wren_q && !app_wdf_rdy_i;
                state_d = (!en_d && !wren_d) ? IDLE : WR;
            end
            RD_CMD: if (app_rdy_i) begin
                en_d    = 1'b0;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (app_rd_data_valid_i) begin
                data_d  = app_rd_data_i[lane_q*DATA_W +: DATA_W];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) && init_calib_complete_i;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            wren_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '1;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            lane_q  <= lane_d;
        end
    end

    // A single-beat read must always arrive as its own last beat.
    always_ff @(posedge sys_clk_i)
        if (!sys_reset_i && state_q == RD_WAIT && app_rd_data_valid_i)
            assert (app_rd_data_end_i);

    assign ready_o        = ready_q;
    assign w_ready_o      = ready_q;
    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign app_addr_o     = addr_q;
    assign app_cmd_o      = cmd_q;
    assign app_en_o       = en_q;
    assign app_wdf_data_o = wdata_q;
    assign app_wdf_mask_o = mask_q;
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_end_o  = wren_q;
endmodule

// File: tb/tb_mig_ui_adapter.sv
// tb_mig_ui_adapter: vector table, corner sequences and random traffic against a word-level memory model.
module tb_mig_ui_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, calib, en_i, w_en_i;
    logic [26:0]  addr_i;
    logic [31:0]  data_i;
    logic [3:0]   strb_i;
    logic         ready_o, w_ready_o, valid_o;
    logic [31:0]  data_o;
    logic [26:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o, app_rdy_i;
    logic [127:0] app_wdf_data_o;
    logic [15:0]  app_wdf_mask_o;
    logic         app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
    logic [127:0] app_rd_data_i;
    logic         app_rd_data_valid_i, app_rd_data_end_i;

    mig_ui_adapter dut (
        .sys_clk_i(clk), .sys_reset_i(rst), .init_calib_complete_i(calib),
        .en_i(en_i), .w_en_i(w_en_i), .addr_i(addr_i), .data_i(data_i), .strb_i(strb_i),
        .ready_o(ready_o), .w_ready_o(w_ready_o), .data_o(data_o), .valid_o(valid_o),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
        .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i),
        .app_rd_data_end_i(app_rd_data_end_i)
    );

    typedef struct {
        bit          we;
        logic [26:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          cd, wd, rl;
        logic [26:0] xa;
        logic [15:0] xm;
        logic [31:0] xr;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [127:0] mig_mem [logic [26:0]];
    logic [31:0]  ref_mem [logic [26:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mig_rd(input logic [26:0] a);
        return mig_mem.exists(a) ? mig_mem[a] : 128'h0;
    endfunction

    function automatic logic [15:0] exp_mask(input logic [26:0] a, input logic [3:0] s);
        logic [15:0] m = '1;
        for (int b = 0; b < 4; b++) if (s[b]) m[a[3:2]*4+b] = 1'b0;
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
        return o;
    endfunction

    task automatic drive_noise();
        en_i   = 1'($urandom);
        w_en_i = 1'($urandom);
        addr_i = 27'($urandom);
        data_i = $urandom;
        strb_i = 4'($urandom);
    endtask

    task automatic chk_rst(input string p);
        chk({p, " ready"}, 128'(ready_o), 0);
        chk({p, " w_ready"}, 128'(w_ready_o), 0);
        chk({p, " valid"}, 128'(valid_o), 0);
        chk({p, " app_en"}, 128'(app_en_o), 0);
        chk({p, " wren"}, 128'(app_wdf_wren_o), 0);
        chk({p, " wdf_end"}, 128'(app_wdf_end_o), 0);
        chk({p, " data_o"}, 128'(data_o), 0);
        chk({p, " app_addr"}, 128'(app_addr_o), 0);
        chk({p, " wdf_data"}, app_wdf_data_o, 0);
        chk({p, " cmd"}, 128'(app_cmd_o), 0);
        chk({p, " mask"}, 128'(app_wdf_mask_o), 128'(16'hFFFF));
    endtask

    task automatic do_txn(input string nm, input bit we, input logic [26:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int cd, input int wd, input int rl, input bit noise,
                          input logic [26:0] xa, input logic [15:0] xm, input logic [31:0] xr);
        int k, cyc, en_cyc, wr_cyc;
        bit cdone, wdone, bad;
        logic [26:0] ca;
        logic [127:0] beat;
        k = 0;
        while (!ready_o && k < 50) begin tick(); k++; end
        chk({nm, " ready_before"}, 128'(ready_o), 1);
        en_i = 1'b1; w_en_i = we; addr_i = a; data_i = d; strb_i = s;
        tick();
        en_i = 1'b0;
        cyc = 0; en_cyc = 0; wr_cyc = 0; cdone = 0; wdone = !we; bad = 0; ca = '0;
        while (!(cdone && wdone) && cyc < 64) begin
            if (ready_o || w_ready_o || valid_o || app_wdf_end_o !== app_wdf_wren_o) bad = 1;
            app_rdy_i = (cyc >= cd);
            app_wdf_rdy_i = (cyc >= wd);
            if (app_en_o) begin
                en_cyc++;
                if (app_rdy_i && !cdone) begin
                    cdone = 1; ca = app_addr_o;
                    chk({nm, " app_addr"}, 128'(app_addr_o), 128'(xa));
                    chk({nm, " cmd"}, 128'(app_cmd_o), 128'(we ? 3'd0 : 3'd1));
                end
            end
            if (app_wdf_wren_o) begin
                wr_cyc++;
                if (app_wdf_rdy_i && !wdone) begin
                    wdone = 1;
                    chk({nm, " wdf_data"}, app_wdf_data_o, {4{d}});
                    chk({nm, " mask"}, 128'(app_wdf_mask_o), 128'(xm));
                    beat = mig_rd(app_addr_o);
                    for (int i = 0; i < 16; i++)
                        if (!app_wdf_mask_o[i]) beat[i*8 +: 8] = app_wdf_data_o[i*8 +: 8];
                    mig_mem[app_addr_o] = beat;
                end
            end
            if (noise) drive_noise();
            tick();
            cyc++;
        end
        en_i = 1'b0; app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
        chk({nm, " handshakes_done"}, 128'(cdone && wdone), 1);
        chk({nm, " app_en_cycles"}, 128'(en_cyc), 128'(cd + 1));
        chk({nm, " wren_cycles"}, 128'(wr_cyc), 128'(we ? wd + 1 : 0));
        if (we) begin
            chk({nm, " busy_outputs"}, 128'(bad), 0);
            chk({nm, " ready_after"}, 128'(ready_o), 1);
            chk({nm, " strobes_low"}, 128'({app_en_o, app_wdf_wren_o}), 0);
        end else begin
            for (int i = 0; i < rl; i++) begin
                if (ready_o || valid_o || app_en_o) bad = 1;
                if (noise) drive_noise();
                tick();
            end
            if (ready_o || valid_o) bad = 1;
            app_rd_data_valid_i = 1'b1; app_rd_data_end_i = 1'b1; app_rd_data_i = mig_rd(ca);
            tick();
            en_i = 1'b0; app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
            app_rd_data_i = {4{$urandom}};
            chk({nm, " busy_outputs"}, 128'(bad), 0);
            chk({nm, " valid"}, 128'(valid_o), 1);
            chk({nm, " data_o"}, 128'(data_o), 128'(xr));
            chk({nm, " ready_after"}, 128'(ready_o), 1);
            tick();
            chk({nm, " valid_pulse_end"}, 128'(valid_o), 0);
            chk({nm, " data_held"}, 128'(data_o), 128'(xr));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        bit we;
        logic [26:0] a;
        logic [31:0] d, xr;
        logic [3:0] s;
        int gate_bad;
        tbl[0] = '{1'b1, 27'h108, 32'hDEADBEEF, 4'hF, 0, 0, 0, 27'h80, 16'hF0FF, 32'h0};
        tbl[1] = '{1'b1, 27'h004, 32'h12345678, 4'h5, 3, 0, 0, 27'h00, 16'hFFAF, 32'h0};
        tbl[2] = '{1'b1, 27'h10C, 32'hAABBCCDD, 4'h3, 1, 2, 0, 27'h80, 16'hCFFF, 32'h0};
        tbl[3] = '{1'b1, 27'h000, 32'hCAFEF00D, 4'h8, 0, 3, 0, 27'h00, 16'hFFF7, 32'h0};
        tbl[4] = '{1'b1, 27'h030, 32'h55555555, 4'h0, 0, 0, 0, 27'h18, 16'hFFFF, 32'h0};
        tbl[5] = '{1'b0, 27'h108, 32'h0, 4'h0, 0, 0, 0, 27'h80, 16'hFFFF, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 27'h004, 32'h0, 4'h0, 2, 0, 3, 27'h00, 16'hFFFF, 32'h00340078};
        tbl[7] = '{1'b0, 27'h10C, 32'h0, 4'h0, 0, 0, 1, 27'h80, 16'hFFFF, 32'h0000CCDD};
        tbl[8] = '{1'b0, 27'h000, 32'h0, 4'h0, 1, 0, 0, 27'h00, 16'hFFFF, 32'hCA000000};
        tbl[9] = '{1'b0, 27'h030, 32'h0, 4'h0, 0, 0, 2, 27'h18, 16'hFFFF, 32'h0};

        rst = 1'b1; calib = 1'b0; en_i = 1'b0; w_en_i = 1'b0; addr_i = '0; data_i = '0; strb_i = '0;
        app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0; app_rd_data_i = '0;
        app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
        repeat (3) tick();
        chk_rst("reset");
        rst = 1'b0;

        en_i = 1'b1; w_en_i = 1'b1; addr_i = 27'h108; strb_i = 4'hF; gate_bad = 0;
        repeat (4) begin
            tick();
            if (ready_o || w_ready_o || app_en_o || app_wdf_wren_o) gate_bad++;
        end
        chk("calib_gate", 128'(gate_bad), 0);
        en_i = 1'b0; calib = 1'b1;
        tick();
        chk("calib_ready", 128'(ready_o), 1);
        chk("calib_w_ready", 128'(w_ready_o), 1);

        for (int i = 0; i < 10; i++)
            do_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].cd,
                   tbl[i].wd, tbl[i].rl, 1'b0, tbl[i].xa, tbl[i].xm, tbl[i].xr);

        mig_mem[27'h80] = 128'h11111111_22222222_33333333_44444444;
        do_txn("rd_lane3", 1'b0, 27'h10C, 32'h0, 4'h0, 0, 0, 3, 1'b0, 27'h80, 16'hFFFF, 32'h11111111);
        app_rd_data_valid_i = 1'b1; app_rd_data_i = '1;
        tick();
        app_rd_data_valid_i = 1'b0;
        chk("stray_valid", 128'(valid_o), 0);
        chk("stray_data", 128'(data_o), 128'(32'h11111111));

        en_i = 1'b1; w_en_i = 1'b0; addr_i = 27'h10C;
        tick();
        en_i = 1'b0; app_rdy_i = 1'b1;
        tick();
        app_rdy_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_rst("midrd");
        rst = 1'b0; app_rd_data_valid_i = 1'b1; app_rd_data_end_i = 1'b1; app_rd_data_i = '1;
        tick();
        app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
        chk("late_ret_valid", 128'(valid_o), 0);
        chk("late_ret_data", 128'(data_o), 0);
        chk("late_ret_app_en", 128'(app_en_o), 0);
        tick();
        chk("late_ret_valid2", 128'(valid_o), 0);
        do_txn("rd_after_rst", 1'b0, 27'h10C, 32'h0, 4'h0, 0, 0, 1, 1'b0, 27'h80, 16'hFFFF, 32'h11111111);

        do_txn("b2b_wr", 1'b1, 27'h020, 32'h0BADCAFE, 4'hF, 1, 0, 0, 1'b1, 27'h10, 16'hFFF0, 32'h0);
        do_txn("b2b_rd", 1'b0, 27'h020, 32'h0, 4'h0, 0, 0, 2, 1'b1, 27'h10, 16'hFFFF, 32'h0BADCAFE);

        mig_mem.delete();
        ref_mem.delete();
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom);
            a  = 27'($urandom_range(0, 63)) << 2;
            d  = $urandom;
            s  = 4'($urandom);
            xr = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
            do_txn($sformatf("rnd%0d", t), we, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4), 1'b1, (a & ~27'hF) >> 1, exp_mask(a, s), xr);
            if (we) ref_mem[a >> 2] = merge(xr, d, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
